dispatch_queue: RTL and testbench

Parametrised in-order instruction queue and dispatcher between the instruction-fetch/decode stage and the Tomasulo back end. It buffers decoded control words in a DEPTH-entry circular buffer and dispatches one per cycle from the head to one of NUM_RS ALU reservation stations, the branch station or the LSQ, gated by ROB space. It replaces the fixed-depth, fixed-4-station queue with round-robin station selection, synchronous flush and an occupancy count.

---
 rtl/dispatch_queue_pkg.sv | 40 ++++
 rtl/dispatch_rr_arbiter.sv | 31 +++
 rtl/dispatch_queue.sv | 131 +++++++++++++
 tb/tb_dispatch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg: control/monitor word types, dispatch classes and the
// op -> dispatch class helper shared by the dispatch queue and its arbiter.
package dispatch_queue_pkg;

    typedef enum logic [2:0] {
        OP_BRANCH = 3'd0,
        OP_ALU_R  = 3'd1,
        OP_ALU_I  = 3'd2,
        OP_LUI    = 3'd3,
        OP_LOAD   = 3'd4,
        OP_STORE  = 3'd5
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word_t;

    typedef struct packed {
        logic [15:0] order;
        logic [31:0] insn;
    } rvfi_word_t;

    typedef enum logic [1:0] {DISP_ALU, DISP_BR, DISP_MEM} disp_class_e;

    // Word presented on ctl_o while the queue is empty.
    localparam ctl_word_t CTL_ZERO = '{op: OP_BRANCH, default: '0};

    function automatic disp_class_e op_class(op_e op);
        case (op)
            OP_BRANCH:         return DISP_BR;
            OP_LOAD, OP_STORE: return DISP_MEM;
            default:           return DISP_ALU;
        endcase
    endfunction

endpackage

// File: rtl/dispatch_rr_arbiter.sv
// dispatch_rr_arbiter: picks the first free ALU station at or after i_ptr,
// wrapping around, and returns it one-hot and as an index.
module dispatch_rr_arbiter #(
    parameter int NUM_RS = 4,
    parameter int RW     = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] i_req,
    input  logic [RW-1:0]     i_ptr,
    output logic [NUM_RS-1:0] o_grant,
    output logic [RW-1:0]     o_idx,
    output logic              o_any
);

    // Rotating priority search starting at the pointer.
    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_RS; i++) begin
            j = (int'(i_ptr) + i) % NUM_RS;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = RW'(j);
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order DEPTH-entry control-word queue dispatching one
// word per cycle from the head to an ALU station (round-robin), the branch
// station or the LSQ, gated by ROB space.
// Optional feature: define DISPATCH_RVFI_EN to store the monitor sidecar
// alongside each control word; otherwise rvfi_o is tied to zero.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  NUM_RS = 4,
    parameter type CTL_T  = ctl_word_t,
    parameter type RVFI_T = rvfi_word_t
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    input  CTL_T                       enq_data_i,
    input  RVFI_T                      enq_rvfi_i,
    output logic                       enq_ready_o,
    input  logic [NUM_RS-1:0]          rs_empty_i,
    input  logic                       resbr_empty_i,
    input  logic                       lsq_empty_i,
    input  logic                       rob_full_i,
    output logic [NUM_RS-1:0]          rs_load_o,
    output logic                       resbr_load_o,
    output logic                       lsq_load_o,
    output logic                       rob_load_o,
    output logic                       regfile_allocate_o,
    output CTL_T                       ctl_o,
    output RVFI_T                      rvfi_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int RW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PW-1:0]     r_head, r_tail;
    logic [CW-1:0]     r_count;
    logic [RW-1:0]     r_rr;
    CTL_T              r_mem [DEPTH];

    logic              w_empty, w_full, w_enq, w_can;
    CTL_T              w_head;
    disp_class_e       w_cls;
    logic [NUM_RS-1:0] w_grant;
    logic [RW-1:0]     w_idx;
    logic              w_any;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign enq_ready_o = ~w_full & ~flush_i & reset_n_i;
    assign w_enq       = enq_valid_i & enq_ready_o;
    assign w_head      = r_mem[r_head];
    assign w_cls       = op_class(w_head.op);
    assign w_can       = ~w_empty & ~rob_full_i & ~flush_i;
    assign ctl_o       = w_empty ? CTL_ZERO : w_head;
    assign count_o     = r_count;

    dispatch_rr_arbiter #(.NUM_RS(NUM_RS), .RW(RW)) u_arb (
        .i_req  (rs_empty_i),
        .i_ptr  (r_rr),
        .o_grant(w_grant),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Same-cycle dispatch decision for the head word.
    always_comb begin
        rs_load_o          = '0;
        resbr_load_o       = 1'b0;
        lsq_load_o         = 1'b0;
        regfile_allocate_o = 1'b0;
        if (w_can) begin
            case (w_cls)
                DISP_BR: resbr_load_o = resbr_empty_i;
                DISP_MEM: begin
                    lsq_load_o         = lsq_empty_i;
                    regfile_allocate_o = lsq_empty_i;
                end
                default: begin
                    rs_load_o          = w_any ? w_grant : '0;
                    regfile_allocate_o = w_any;
                end
            endcase
        end
        rob_load_o = resbr_load_o | lsq_load_o | (|rs_load_o);
    end

    // Pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rr    <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)      r_tail <= r_tail + PW'(1);
            if (rob_load_o) r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(rob_load_o);
            if (|rs_load_o)
                r_rr <= (w_idx == RW'(NUM_RS-1)) ? '0 : w_idx + RW'(1);
        end
    end

    // Control-word storage, written at the tail on accepted enqueue.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_tail] <= enq_data_i;
    end

`ifdef DISPATCH_RVFI_EN
    RVFI_T r_rvfi [DEPTH];

    // Monitor sidecar storage sharing the control-word pointers.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_rvfi[r_tail] <= enq_rvfi_i;
    end

    assign rvfi_o = w_empty ? '0 : r_rvfi[r_head];
`else
    logic w_unused_rvfi;
    assign w_unused_rvfi = ^enq_rvfi_i;
    assign rvfi_o        = '0;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed stimulus with hand-computed expectations for
// dispatch_queue (DEPTH=8, NUM_RS=4).
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int DEPTH  = 8;
    localparam int NUM_RS = 4;

    logic              clk_i, reset_n_i, flush_i, enq_valid_i, enq_ready_o;
    ctl_word_t         enq_data_i, ctl_o;
    rvfi_word_t        enq_rvfi_i, rvfi_o;
    logic [NUM_RS-1:0] rs_empty_i, rs_load_o;
    logic              resbr_empty_i, lsq_empty_i, rob_full_i;
    logic              resbr_load_o, lsq_load_o, rob_load_o, regfile_allocate_o;
    logic [3:0]        count_o;

    int checks   = 0;
    int failures = 0;
    int exp_rr;
    int exp_cnt;
    logic [31:0] expq [$];
    logic [31:0] exp_imm;

    dispatch_queue #(.DEPTH(DEPTH), .NUM_RS(NUM_RS)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_data_i(enq_data_i), .enq_rvfi_i(enq_rvfi_i),
        .enq_ready_o(enq_ready_o), .rs_empty_i(rs_empty_i),
        .resbr_empty_i(resbr_empty_i), .lsq_empty_i(lsq_empty_i), .rob_full_i(rob_full_i),
        .rs_load_o(rs_load_o), .resbr_load_o(resbr_load_o), .lsq_load_o(lsq_load_o),
        .rob_load_o(rob_load_o), .regfile_allocate_o(regfile_allocate_o),
        .ctl_o(ctl_o), .rvfi_o(rvfi_o), .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic ctl_word_t mk(input op_e op, input logic [4:0] rd, input logic [31:0] imm);
        return '{op: op, rd: rd, rs1: 5'd1, rs2: 5'd2, imm: imm};
    endfunction

    task automatic push(input ctl_word_t w);
        enq_valid_i = 1'b1;
        enq_data_i  = w;
        enq_rvfi_i  = '{order: w.imm[15:0], insn: 32'hdead};
        tick();
        enq_valid_i = 1'b0;
    endtask

    initial begin
        reset_n_i = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0;
        enq_data_i = '0; enq_rvfi_i = '0; rs_empty_i = '0;
        resbr_empty_i = 1'b0; lsq_empty_i = 1'b0; rob_full_i = 1'b0;

        // Reset state
        #3;
        chk("rst_ready", 64'(enq_ready_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_rob_load", 64'(rob_load_o), 64'd0);
        chk("rst_ctl", 64'(ctl_o), 64'(CTL_ZERO));
        tick(); tick();
        reset_n_i = 1'b1;
        #1;
        chk("post_rst_ready", 64'(enq_ready_o), 64'd1);

        // Three ALU words dispatched round-robin from station 0
        rob_full_i = 1'b1; rs_empty_i = 4'hF;
        for (int i = 0; i < 3; i++) push(mk(OP_ALU_R, 5'(i + 1), 32'(i)));
        chk("alu3_count", 64'(count_o), 64'd3);
        rob_full_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("alu3_rs_load", 64'(rs_load_o), 64'(1 << i));
            chk("alu3_rob_load", 64'(rob_load_o), 64'd1);
            chk("alu3_alloc", 64'(regfile_allocate_o), 64'd1);
            chk("alu3_rd", 64'(ctl_o.rd), 64'(i + 1));
            tick();
            chk("alu3_cnt", 64'(count_o), 64'(2 - i));
        end
        chk("alu3_idle_rob", 64'(rob_load_o), 64'd0);
        exp_rr = 3;

        // Fill to DEPTH with ROB full; ninth word refused
        rob_full_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            enq_valid_i = 1'b1;
            enq_data_i  = mk(OP_ALU_I, 5'd9, 32'(100 + i));
            enq_rvfi_i  = '{order: 16'(100 + i), insn: 32'hdead};
            #1;
            chk("fill_ready", 64'(enq_ready_o), (i < 8) ? 64'd1 : 64'd0);
            if (i < 8) expq.push_back(32'(100 + i));
            tick();
        end
        enq_valid_i = 1'b0;
        chk("full_count", 64'(count_o), 64'd8);
        chk("full_ready", 64'(enq_ready_o), 64'd0);

        // Drain in order; refused enqueue while full, accepted one alongside a dispatch
        exp_cnt = 8;
        rob_full_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            enq_valid_i = (i < 2);
            enq_data_i  = mk(OP_ALU_R, 5'd3, 32'd200);
            #1;
            if (i < 2) chk("drain_ready", 64'(enq_ready_o), (i == 0) ? 64'd0 : 64'd1);
            if (i == 1) expq.push_back(32'd200);
            exp_imm = expq.pop_front();
            chk("drain_imm", 64'(ctl_o.imm), 64'(exp_imm));
            chk("drain_rs_load", 64'(rs_load_o), 64'(1 << exp_rr));
            chk("drain_rob_load", 64'(rob_load_o), 64'd1);
            if (i == 0) begin
`ifdef DISPATCH_RVFI_EN
                chk("drain_rvfi", 64'(rvfi_o), 64'({16'd100, 32'hdead}));
`else
                chk("drain_rvfi", 64'(rvfi_o), 64'd0);
`endif
            end
            exp_rr  = (exp_rr + 1) % NUM_RS;
            exp_cnt = exp_cnt + ((i == 1) ? 1 : 0) - 1;
            tick();
            enq_valid_i = 1'b0;
            chk("drain_count", 64'(count_o), 64'(exp_cnt));
        end

        // Branch head waits for the branch station
        resbr_empty_i = 1'b0; lsq_empty_i = 1'b1;
        push(mk(OP_BRANCH, 5'd0, 32'h55));
        chk("br_count", 64'(count_o), 64'd1);
        chk("br_wait_rob", 64'(rob_load_o), 64'd0);
        chk("br_wait_resbr", 64'(resbr_load_o), 64'd0);
        chk("br_wait_lsq", 64'(lsq_load_o), 64'd0);
        tick();
        chk("br_still_count", 64'(count_o), 64'd1);
        resbr_empty_i = 1'b1;
        #1;
        chk("br_resbr", 64'(resbr_load_o), 64'd1);
        chk("br_rob", 64'(rob_load_o), 64'd1);
        chk("br_alloc", 64'(regfile_allocate_o), 64'd0);
        chk("br_rs", 64'(rs_load_o), 64'd0);
        tick();
        chk("br_done_count", 64'(count_o), 64'd0);

        // Load head goes to the LSQ and allocates a register
        lsq_empty_i = 1'b0; rs_empty_i = 4'h0;
        push(mk(OP_LOAD, 5'd5, 32'd8));
        chk("ld_wait_rob", 64'(rob_load_o), 64'd0);
        lsq_empty_i = 1'b1;
        #1;
        chk("ld_lsq", 64'(lsq_load_o), 64'd1);
        chk("ld_alloc", 64'(regfile_allocate_o), 64'd1);
        chk("ld_rs", 64'(rs_load_o), 64'd0);
        chk("ld_resbr", 64'(resbr_load_o), 64'd0);
        tick();
        chk("ld_count", 64'(count_o), 64'd0);

        // Round-robin pointer untouched by non-ALU dispatch; busy stations skipped
        rob_full_i = 1'b1; rs_empty_i = 4'hF;
        push(mk(OP_ALU_R, 5'd1, 32'd1));
        push(mk(OP_LUI, 5'd2, 32'd2));
        rob_full_i = 1'b0;
        #1;
        chk("rr_keep", 64'(rs_load_o), 64'b0001);
        tick();
        rs_empty_i = 4'b1100;
        #1;
        chk("rr_skip", 64'(rs_load_o), 64'b0100);
        tick();
        chk("rr_count", 64'(count_o), 64'd0);

        // Flush with concurrent enqueue
        rob_full_i = 1'b1; rs_empty_i = 4'hF;
        for (int i = 0; i < 5; i++) push(mk(OP_ALU_R, 5'd4, 32'(300 + i)));
        chk("fl_count5", 64'(count_o), 64'd5);
        flush_i = 1'b1; enq_valid_i = 1'b1; rob_full_i = 1'b0;
        #1;
        chk("fl_ready", 64'(enq_ready_o), 64'd0);
        chk("fl_rob", 64'(rob_load_o), 64'd0);
        chk("fl_rs", 64'(rs_load_o), 64'd0);
        chk("fl_alloc", 64'(regfile_allocate_o), 64'd0);
        tick();
        flush_i = 1'b0; enq_valid_i = 1'b0;
        chk("fl_count0", 64'(count_o), 64'd0);
        chk("fl_ctl", 64'(ctl_o), 64'(CTL_ZERO));
        chk("fl_idle_rob", 64'(rob_load_o), 64'd0);
        push(mk(OP_ALU_R, 5'd7, 32'd7));
        chk("fl_rr_kept", 64'(rs_load_o), 64'b1000);
        chk("fl_rd", 64'(ctl_o.rd), 64'd7);
        tick();
        chk("fl_after_count", 64'(count_o), 64'd0);

        // Asynchronous reset mid-stream
        rob_full_i = 1'b1;
        push(mk(OP_ALU_R, 5'd8, 32'd8));
        push(mk(OP_ALU_R, 5'd9, 32'd9));
        chk("ar_count2", 64'(count_o), 64'd2);
        rob_full_i = 1'b0;
        reset_n_i  = 1'b0;
        #1;
        chk("ar_count", 64'(count_o), 64'd0);
        chk("ar_ctl", 64'(ctl_o), 64'(CTL_ZERO));
        chk("ar_rob", 64'(rob_load_o), 64'd0);
        chk("ar_rs", 64'(rs_load_o), 64'd0);
        chk("ar_ready", 64'(enq_ready_o), 64'd0);
        tick();
        reset_n_i = 1'b1;
        #1;
        chk("ar_rel_ready", 64'(enq_ready_o), 64'd1);
        chk("ar_rel_count", 64'(count_o), 64'd0);
        push(mk(OP_ALU_R, 5'd10, 32'd10));
        chk("ar_rr_reset", 64'(rs_load_o), 64'b0001);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
